mfcc_feat_buffer: RTL and testbench

// - Receiving end of the MFCC/DCT coefficient stream: takes serial signed DCT coefficients (one strobe per coefficient, end-of-frame pulse) and assembles them into frames.
// - Stores complete frames in a circular frame buffer (depth NUM_FRAMES).
// - Exposes a random-access read port (frame index relative to oldest, coefficient index) plus pop, for the downstream keyword/template matcher.

---
 rtl/mfcc_feat_buffer_if.sv | 30 +++
 rtl/mfcc_feat_buffer.sv | 132 +++++++++++++
 tb/tb_mfcc_feat_buffer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mfcc_feat_buffer_if.sv
// Bundle of the coefficient-stream, random-access read and status signals of mfcc_feat_buffer.
// master = coefficient producer / matcher side, slave = the frame buffer.
interface mfcc_feat_buffer_if #(
    parameter int DATA_W   = 14,
    parameter int COEF_AW  = 4,
    parameter int FRAME_AW = 5
);
    logic signed [DATA_W-1:0] dct_data;
    logic                     dct_valid;
    logic                     dct_frame_end;
    logic                     rd_en;
    logic [FRAME_AW-1:0]      rd_frame;
    logic [COEF_AW-1:0]       rd_coef;
    logic signed [DATA_W-1:0] rd_data;
    logic                     rd_valid;
    logic                     pop;
    logic [FRAME_AW:0]        frame_cnt;
    logic                     frame_rdy;
    logic                     frame_err;

    modport master (
        output dct_data, dct_valid, dct_frame_end, rd_en, rd_frame, rd_coef, pop,
        input  rd_data, rd_valid, frame_cnt, frame_rdy, frame_err
    );

    modport slave (
        input  dct_data, dct_valid, dct_frame_end, rd_en, rd_frame, rd_coef, pop,
        output rd_data, rd_valid, frame_cnt, frame_rdy, frame_err
    );
endinterface

// File: rtl/mfcc_feat_buffer.sv
// Assembles serial DCT coefficients into frames held in a circular block-RAM frame buffer.
// Optional MFCC_FEAT_OVERWRITE_EN: a good frame committed while full replaces the oldest frame.
module mfcc_feat_buffer #(
    parameter int DATA_W     = 14,
    parameter int NUM_COEF   = 13,
    parameter int COEF_AW    = 4,
    parameter int NUM_FRAMES = 32,
    parameter int FRAME_AW   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    mfcc_feat_buffer_if.slave bus
);

`ifdef MFCC_FEAT_OVERWRITE_EN
    localparam bit OVERWRITE = 1'b1;
`else
    localparam bit OVERWRITE = 1'b0;
`endif

    localparam int                ADDR_W     = FRAME_AW + COEF_AW;
    localparam logic [COEF_AW:0]  NUM_COEF_L = (COEF_AW+1)'(NUM_COEF);
    localparam logic [FRAME_AW:0] FULL_CNT   = (FRAME_AW+1)'(NUM_FRAMES);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMMIT} state_t;

    state_t              state_q;
    logic [FRAME_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [COEF_AW:0]    cnt_q;
    logic                ovf_q;
    logic [FRAME_AW:0]   frame_cnt_q;
    logic                frame_rdy_q, frame_err_q;
    logic                rd_valid_q, rd_ok_q;
    logic [DATA_W-1:0]   ram_rd_q;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic             full, pop_ok, accept, end_now, room, wr_en;
    logic [COEF_AW:0] base_cnt, eff_cnt;
    logic             base_ovf, eff_ovf, good, commit_ok, ovw;
    logic             cnt_inc, cnt_dec, rd_in_range;
    logic [ADDR_W-1:0] wr_addr, rd_addr;

    // The cycle after a frame end is the commit cycle; stream inputs are ignored there.
    always_comb begin
        full      = (frame_cnt_q == FULL_CNT);
        pop_ok    = bus.pop && (frame_cnt_q != '0);
        accept    = bus.dct_valid && (state_q != S_COMMIT);
        end_now   = bus.dct_frame_end && (state_q != S_COMMIT);
        base_cnt  = (state_q == S_IDLE) ? '0 : cnt_q;
        base_ovf  = (state_q == S_IDLE) ? 1'b0 : ovf_q;
        room      = (base_cnt < NUM_COEF_L);
        // While full (no overwrite) writes would clobber the oldest stored frame, so they are
        // suppressed and the frame is marked bad even if a pop frees a slot mid-frame.
        wr_en     = accept && room && (!full || OVERWRITE);
        eff_cnt   = base_cnt + {{COEF_AW{1'b0}}, accept && room};
        eff_ovf   = base_ovf || (accept && !room) || (accept && full && !OVERWRITE);
        good      = (eff_cnt == NUM_COEF_L) && !eff_ovf;
        commit_ok = end_now && good && (!full || OVERWRITE);
        ovw       = commit_ok && full;
        cnt_inc   = commit_ok && !full;
        cnt_dec   = pop_ok && !ovw;
        wr_addr   = {wr_ptr_q, base_cnt[COEF_AW-1:0]};
        rd_addr   = {rd_ptr_q + bus.rd_frame, bus.rd_coef};
        rd_in_range = ({1'b0, bus.rd_frame} < frame_cnt_q) && ({1'b0, bus.rd_coef} < NUM_COEF_L);
    end

    // Read-first RAM: a same-cycle write to the read address returns the previous contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= bus.dct_data;
        end
        if (bus.rd_en) begin
            ram_rd_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= '0;
            frame_rdy_q <= 1'b0;
            frame_err_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_ok_q     <= 1'b0;
        end else begin
            frame_rdy_q <= 1'b0;
            frame_err_q <= 1'b0;
            rd_valid_q  <= bus.rd_en;
            rd_ok_q     <= bus.rd_en && rd_in_range;

            case (state_q)
                S_IDLE, S_COLLECT: begin
                    if (accept) begin
                        cnt_q <= eff_cnt;
                        ovf_q <= eff_ovf;
                    end
                    if (end_now) begin
                        state_q     <= S_COMMIT;
                        frame_rdy_q <= commit_ok;
                        frame_err_q <= !commit_ok;
                    end else if (accept) begin
                        state_q <= S_COLLECT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (commit_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok || ovw) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({cnt_inc, cnt_dec})
                2'b10:   frame_cnt_q <= frame_cnt_q + 1'b1;
                2'b01:   frame_cnt_q <= frame_cnt_q - 1'b1;
                default: frame_cnt_q <= frame_cnt_q;
            endcase
        end
    end

    assign bus.rd_data   = rd_ok_q ? ram_rd_q : '0;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.frame_rdy = frame_rdy_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_mfcc_feat_buffer.sv
// Self-checking bench for mfcc_feat_buffer: table of frame vectors plus hand-written corner sequences,
// with a queue scoreboard for read results.
module tb_mfcc_feat_buffer;
    localparam int DATA_W = 14, NUM_COEF = 13, COEF_AW = 4, NUM_FRAMES = 32, FRAME_AW = 5;

    typedef logic signed [DATA_W-1:0] coef_t;
    typedef logic [NUM_COEF-1:0][DATA_W-1:0] frame_t;

    typedef struct {
        int ncoef;
        int base;
        int step;
        bit end_with_last;
        bit do_pop;
        bit exp_rdy;
        bit exp_err;
        int exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mfcc_feat_buffer_if #(.DATA_W(DATA_W), .COEF_AW(COEF_AW), .FRAME_AW(FRAME_AW)) bus ();

    mfcc_feat_buffer #(
        .DATA_W(DATA_W), .NUM_COEF(NUM_COEF), .COEF_AW(COEF_AW),
        .NUM_FRAMES(NUM_FRAMES), .FRAME_AW(FRAME_AW)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int     checks = 0;
    int     errors = 0;
    coef_t  sb[$];
    frame_t model_q[$];
    coef_t  fbuf [16];
    vec_t   vecs [7];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read scoreboard: expected data pushed when rd_en is driven, popped when rd_valid appears.
    always @(negedge clk) begin
        if (rst_n && bus.rd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_spurious: got rd_valid=1 expected no pending read");
            end else begin
                chk("rd_data", longint'(bus.rd_data), longint'(sb.pop_front()));
            end
        end
    end

    task automatic fill(input int base, input int step);
        for (int k = 0; k < 16; k++) fbuf[k] = coef_t'(base + k * step);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.dct_data = '0; bus.dct_valid = 1'b0; bus.dct_frame_end = 1'b0;
        bus.rd_en = 1'b0; bus.rd_frame = '0; bus.rd_coef = '0; bus.pop = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        model_q.delete();
        sb.delete();
    endtask

    task automatic send_frame(input string tag, input int n, input bit end_last, input bit do_pop,
                              input bit exp_rdy, input bit exp_err, input int exp_cnt);
        frame_t fr;
        for (int k = 0; k < n; k++) begin
            bus.dct_valid     = 1'b1;
            bus.dct_data      = fbuf[k];
            bus.dct_frame_end = end_last && (k == n - 1);
            bus.pop           = do_pop && end_last && (k == n - 1);
            tick();
        end
        if (!(end_last && n > 0)) begin
            bus.dct_valid     = 1'b0;
            bus.dct_frame_end = 1'b1;
            bus.pop           = do_pop;
            tick();
        end
        bus.dct_valid = 1'b0; bus.dct_frame_end = 1'b0; bus.pop = 1'b0;
        chk({tag, "_rdy"}, longint'(bus.frame_rdy), longint'(exp_rdy));
        chk({tag, "_err"}, longint'(bus.frame_err), longint'(exp_err));
        chk({tag, "_cnt"}, longint'(bus.frame_cnt), longint'(exp_cnt));
        if (exp_rdy) begin
            if (do_pop || model_q.size() == NUM_FRAMES) void'(model_q.pop_front());
            for (int k = 0; k < NUM_COEF; k++) fr[k] = fbuf[k];
            model_q.push_back(fr);
        end
        tick();
        chk({tag, "_pulse"}, longint'({bus.frame_rdy, bus.frame_err}), 0);
        $display("frame %s n=%0d rdy=%0b err=%0b cnt=%0d", tag, n, exp_rdy, exp_err, exp_cnt);
    endtask

    task automatic rd(input int f, input int c, input coef_t exp);
        bus.rd_en    = 1'b1;
        bus.rd_frame = FRAME_AW'(f);
        bus.rd_coef  = COEF_AW'(c);
        sb.push_back(exp);
        tick();
        bus.rd_en = 1'b0;
        @(negedge clk);
        #1;
        chk("rd_latency", longint'(sb.size()), 0);
        sb.delete();
        $display("read frame=%0d coef=%0d expect=%0d", f, c, exp);
    endtask

    initial begin
        // ncoef base step end_last pop rdy err cnt
        vecs[0] = '{13,    0,  10, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[1] = '{12,  500,   1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        vecs[2] = '{14,  600,   1, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        vecs[3] = '{ 0,    0,   0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
        vecs[4] = '{13,  100,  -7, 1'b1, 1'b0, 1'b1, 1'b0, 2};
        vecs[5] = '{13, -300,   3, 1'b0, 1'b1, 1'b1, 1'b0, 2};
        vecs[6] = '{12,    0,   1, 1'b1, 1'b0, 1'b0, 1'b1, 2};

        do_reset();
        chk("rst_cnt", longint'(bus.frame_cnt), 0);
        chk("rst_flags", longint'({bus.rd_valid, bus.frame_rdy, bus.frame_err}), 0);
        chk("rst_rd_data", longint'(bus.rd_data), 0);

        bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        chk("pop_empty_cnt", longint'(bus.frame_cnt), 0);

        for (int i = 0; i < 7; i++) begin
            fill(vecs[i].base, vecs[i].step);
            send_frame($sformatf("vec%0d", i), vecs[i].ncoef, vecs[i].end_with_last, vecs[i].do_pop,
                       vecs[i].exp_rdy, vecs[i].exp_err, vecs[i].exp_cnt);
            if (i == 0) rd(0, 5, coef_t'(50));
        end
        for (int f = 0; f < 2; f++)
            for (int c = 0; c < NUM_COEF; c += 6)
                rd(f, c, coef_t'(model_q[f][c]));
        rd(2, 0, '0);
        rd(0, 13, '0);
        rd(0, 15, '0);

        // pop coinciding with a successful commit at frame_cnt=5
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fill(0, 1); fbuf[0] = coef_t'(10 + i);
            send_frame($sformatf("pc%0d", i), 13, 1'b0, 1'b0, 1'b1, 1'b0, i + 1);
        end
        fill(0, 1); fbuf[0] = coef_t'(15);
        send_frame("pc_pop", 13, 1'b1, 1'b1, 1'b1, 1'b0, 5);
        rd(0, 0, coef_t'(11));
        rd(4, 0, coef_t'(15));

        // reset asserted mid-frame drops the partial frame and empties the buffer
        do_reset();
        fill(40, 2);
        send_frame("pre_rst", 13, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        for (int k = 0; k < 6; k++) begin
            bus.dct_valid = 1'b1; bus.dct_data = coef_t'(777);
            tick();
        end
        bus.dct_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("midrst_cnt", longint'(bus.frame_cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();
        model_q.delete();
        fill(300, 1);
        send_frame("post_rst", 13, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        for (int c = 0; c < NUM_COEF; c++) rd(0, c, coef_t'(300 + c));

        // 33 good frames without pop
        do_reset();
        for (int i = 0; i < 33; i++) begin
            fill(1000, 1); fbuf[0] = coef_t'(i);
`ifdef MFCC_FEAT_OVERWRITE_EN
            send_frame($sformatf("full%0d", i), 13, 1'b0, 1'b0, 1'b1, 1'b0, (i < 32) ? i + 1 : 32);
`else
            send_frame($sformatf("full%0d", i), 13, 1'b0, 1'b0, (i < 32), (i == 32), (i < 32) ? i + 1 : 32);
`endif
        end
`ifdef MFCC_FEAT_OVERWRITE_EN
        rd(0, 0, coef_t'(1));
        rd(31, 0, coef_t'(32));
`else
        rd(0, 0, coef_t'(0));
        rd(31, 0, coef_t'(31));
`endif
        rd(31, 5, coef_t'(1005));

        // extreme two's-complement values round-trip
        do_reset();
        fill(0, -5); fbuf[0] = coef_t'(-8192); fbuf[12] = coef_t'(8191);
        send_frame("ext", 13, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        rd(0, 0, coef_t'(-8192));
        rd(0, 12, coef_t'(8191));
        rd(0, 7, coef_t'(-35));
        rd(0, 13, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
